// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared widths and read-owner encoding for the memory port arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_LS   = 2'b10
  } own_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2 : two-input round-robin arbiter, req[0]=IF, req[1]=LS
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0 = IF won last, 1 = LS won last; resetting to IF hands LS the first conflict
  logic r_last_ls;

  always_comb begin
    gnt = 2'b00;
    if (RESET_N) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = r_last_ls ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last_ls <= 1'b0;
    end else if (gnt != 2'b00) begin
      r_last_ls <= gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter : shares one sync-read memory port between IF and LS units
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  own_t       w_own_in;
  own_t       r_own [MEM_LAT+1];

  assign w_req = {ls_req, if_req};

  rr_arb2 u_arb (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .req     (w_req),
    .gnt     (w_gnt)
  );

  assign if_gnt = w_gnt[0];
  assign ls_gnt = w_gnt[1];

  // Address/data hold when idle; only the write strobe is forced low
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (ls_gnt) begin
      mem_we    <= ls_we;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
    end else if (if_gnt) begin
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  always_comb begin
    w_own_in = OWN_NONE;
    if (ls_gnt && !ls_we) begin
      w_own_in = OWN_LS;
    end else if (if_gnt) begin
      w_own_in = OWN_IF;
    end
  end

  // Stage 0 travels with the issued command; the last stage lines up with mem_rdata
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i <= MEM_LAT; i++) begin
        r_own[i] <= OWN_NONE;
      end
    end else begin
      r_own[0] <= w_own_in;
      for (int i = 1; i <= MEM_LAT; i++) begin
        r_own[i] <= r_own[i-1];
      end
    end
  end

  assign if_rvalid = (r_own[MEM_LAT] == OWN_IF);
  assign ls_rvalid = (r_own[MEM_LAT] == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : directed vector table, reset corner, random scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        if_req, ls_req, ls_we;
  logic [15:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we;
  logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous-read memory, one cycle latency
  logic [15:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (i < 7) ? 16'((i + 1) * 100) : 16'h0;
  end
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[5:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [15:0] ls_wdata;
    logic        e_if_gnt;
    logic        e_ls_gnt;
    logic        e_if_rv;
    logic        e_ls_rv;
    logic [15:0] e_rdata;
    logic        e_mem_we;
    logic [15:0] e_mem_addr;
  } vec_t;

  function automatic vec_t mk(int rst, int ireq, int iaddr, int lreq, int lwe, int laddr,
                              int lwd, int eig, int elg, int eirv, int elrv, int erd,
                              int ewe, int eaddr);
    vec_t v;
    v.rst_n      = 1'(rst);
    v.if_req     = 1'(ireq);
    v.if_addr    = 16'(iaddr);
    v.ls_req     = 1'(lreq);
    v.ls_we      = 1'(lwe);
    v.ls_addr    = 16'(laddr);
    v.ls_wdata   = 16'(lwd);
    v.e_if_gnt   = 1'(eig);
    v.e_ls_gnt   = 1'(elg);
    v.e_if_rv    = 1'(eirv);
    v.e_ls_rv    = 1'(elrv);
    v.e_rdata    = 16'(erd);
    v.e_mem_we   = 1'(ewe);
    v.e_mem_addr = 16'(eaddr);
    return v;
  endfunction

  vec_t vecs [19];

  // Random-phase scoreboard state
  logic [15:0] sh [8];
  logic [1:0]  p0_own, p1_own, n_own;
  logic [15:0] p0_dat, p1_dat, n_dat;
  logic        lw_ls, e_ig, e_lg, quiet;

  initial begin
    RESET_N = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;

    //           rst ireq ia lreq lwe la lwd     eig elg eirv elrv erd     ewe ea
    vecs[0]  = mk(0, 1, 0, 1, 0, 6, 0,          0, 0, 0, 0, 0,          0, 0);
    vecs[1]  = mk(0, 1, 0, 1, 0, 6, 0,          0, 0, 0, 0, 0,          0, 0);
    vecs[2]  = mk(1, 1, 0, 1, 0, 6, 0,          0, 1, 0, 0, 0,          0, 0);
    vecs[3]  = mk(1, 1, 0, 1, 0, 6, 0,          1, 0, 0, 0, 0,          0, 6);
    vecs[4]  = mk(1, 1, 0, 1, 0, 6, 0,          0, 1, 0, 1, 700,        0, 0);
    vecs[5]  = mk(1, 1, 0, 1, 0, 6, 0,          1, 0, 1, 0, 100,        0, 6);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 1, 700,        0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 1, 0, 100,        0, 0);
    vecs[8]  = mk(1, 1, 3, 0, 0, 0, 0,          1, 0, 0, 0, 0,          0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0,          0, 3);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 1, 0, 400,        0, 3);
    vecs[11] = mk(1, 0, 0, 1, 1, 5, 16'hBEEF,   0, 1, 0, 0, 0,          0, 3);
    vecs[12] = mk(1, 0, 0, 1, 0, 5, 0,          0, 1, 0, 0, 0,          1, 5);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0,          0, 5);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 1, 16'hBEEF,   0, 5);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0,          0, 5);
    vecs[16] = mk(1, 1, 2, 1, 0, 1, 0,          1, 0, 0, 0, 0,          0, 5);
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0,          0, 2);
    vecs[18] = mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 1, 0, 300,        0, 2);

    for (int k = 0; k < 19; k++) begin
      @(negedge CLK);
      RESET_N  = vecs[k].rst_n;
      if_req   = vecs[k].if_req;   if_addr = vecs[k].if_addr;
      ls_req   = vecs[k].ls_req;   ls_we   = vecs[k].ls_we;
      ls_addr  = vecs[k].ls_addr;  ls_wdata = vecs[k].ls_wdata;
      #1;
      chk($sformatf("v%0d if_gnt", k),    32'(if_gnt),    32'(vecs[k].e_if_gnt));
      chk($sformatf("v%0d ls_gnt", k),    32'(ls_gnt),    32'(vecs[k].e_ls_gnt));
      chk($sformatf("v%0d if_rvalid", k), 32'(if_rvalid), 32'(vecs[k].e_if_rv));
      chk($sformatf("v%0d ls_rvalid", k), 32'(ls_rvalid), 32'(vecs[k].e_ls_rv));
      if (vecs[k].e_if_rv) chk($sformatf("v%0d if_rdata", k), 32'(if_rdata), 32'(vecs[k].e_rdata));
      if (vecs[k].e_ls_rv) chk($sformatf("v%0d ls_rdata", k), 32'(ls_rdata), 32'(vecs[k].e_rdata));
      chk($sformatf("v%0d mem_we", k),    32'(mem_we),    32'(vecs[k].e_mem_we));
      chk($sformatf("v%0d mem_addr", k),  32'(mem_addr),  32'(vecs[k].e_mem_addr));
    end

    // Reset while an IF read is in flight: it must never return
    @(negedge CLK);
    if_req = 1'b1; if_addr = 16'd1;
    #1 chk("midrst if_gnt", 32'(if_gnt), 32'd1);
    @(negedge CLK);
    if_req = 1'b0; RESET_N = 1'b0;
    #1;
    chk("midrst mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst mem_we", 32'(mem_we), 32'd0);
    chk("midrst if_rvalid", 32'(if_rvalid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (k == 2) RESET_N = 1'b1;
      #1;
      chk("midrst late if_rvalid", 32'(if_rvalid), 32'd0);
      chk("midrst late ls_rvalid", 32'(ls_rvalid), 32'd0);
    end

    // Random request/drop traffic against a round-robin + shadow-memory model
    for (int i = 0; i < 8; i++) sh[i] = (i < 7) ? 16'((i + 1) * 100) : 16'h0;
    sh[5] = 16'hBEEF;
    lw_ls = 1'b0;
    p0_own = 2'b00; p1_own = 2'b00; p0_dat = '0; p1_dat = '0;
    e_ig = 1'b0; e_lg = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      quiet = (c >= 196);
      if (quiet) begin
        if_req = 1'b0; ls_req = 1'b0;
      end else begin
        if (!if_req || e_ig) begin
          if_req  = ($urandom_range(0, 3) != 0);
          if_addr = 16'($urandom_range(0, 7));
        end else if ($urandom_range(0, 7) == 0) begin
          if_req = 1'b0;
        end
        if (!ls_req || e_lg) begin
          ls_req   = ($urandom_range(0, 3) != 0);
          ls_we    = ($urandom_range(0, 2) == 0);
          ls_addr  = 16'($urandom_range(0, 7));
          ls_wdata = 16'($urandom_range(0, 65535));
        end else if ($urandom_range(0, 7) == 0) begin
          ls_req = 1'b0;
        end
      end
      e_ig = if_req && (!ls_req || lw_ls);
      e_lg = ls_req && (!if_req || !lw_ls);
      #1;
      chk($sformatf("rnd%0d gnt", c), 32'({if_gnt, ls_gnt}), 32'({e_ig, e_lg}));
      chk($sformatf("rnd%0d rvalid", c), 32'({if_rvalid, ls_rvalid}),
          32'({p1_own == 2'b01, p1_own == 2'b10}));
      if (p1_own == 2'b01) chk($sformatf("rnd%0d if_rdata", c), 32'(if_rdata), 32'(p1_dat));
      if (p1_own == 2'b10) chk($sformatf("rnd%0d ls_rdata", c), 32'(ls_rdata), 32'(p1_dat));
      n_own = 2'b00; n_dat = '0;
      if (e_lg) begin
        if (ls_we) sh[ls_addr[2:0]] = ls_wdata;
        else begin n_own = 2'b10; n_dat = sh[ls_addr[2:0]]; end
        lw_ls = 1'b1;
      end else if (e_ig) begin
        n_own = 2'b01; n_dat = sh[if_addr[2:0]];
        lw_ls = 1'b0;
      end
      p1_own = p0_own; p1_dat = p0_dat;
      p0_own = n_own;  p0_dat = n_dat;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
